// File: rtl/program_loader_pkg.sv
// Shared state encoding and default response bytes for the boot program loader.
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_CHECK,
        S_LOAD,
        S_ACK,
        S_RUN,
        S_ERR
    } state_e;

    localparam int          DEFAULT_IMEM_WORDS = 32;
    localparam int          DEFAULT_ADDR_W     = 5;
    localparam logic [7:0]  DEFAULT_ACK_BYTE   = 8'hAA;
    localparam logic [7:0]  DEFAULT_ERR_BYTE   = 8'hEE;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream, transmit handshake, imem write port and core control of the loader.
interface program_loader_if #(
    parameter int ADDR_W = 5
) ();

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rstn;
    logic              busy;
    logic              load_err;

    modport master (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, imem_we, imem_addr, imem_wdata,
        output core_rstn, busy, load_err
    );

    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, imem_we, imem_addr, imem_wdata,
        input  core_rstn, busy, load_err
    );

endinterface

// File: rtl/program_loader_byte_to_word.sv
// Little-endian 4-byte assembler; word_valid pulses combinationally with the 4th byte.
module byte_to_word (
    input  logic        clk,
    input  logic        rstn,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_cnt,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    // Earlier bytes slide down so the first byte ends up in bits 7:0.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (byte_valid) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {byte_data, shift_q[23:8]};
        end
    end

    assign word_valid = byte_valid && (cnt_q == 2'd3);
    assign word       = {byte_data, shift_q};
    assign byte_cnt   = cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot sequencer: receives a length-prefixed program over the byte stream, writes imem,
// then acknowledges and releases the core (or reports a length error and keeps it in reset).
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         IMEM_WORDS = DEFAULT_IMEM_WORDS,
    parameter int         ADDR_W     = DEFAULT_ADDR_W,
    parameter logic [7:0] ACK_BYTE   = DEFAULT_ACK_BYTE,
    parameter logic [7:0] ERR_BYTE   = DEFAULT_ERR_BYTE
) (
    input  logic           clk,
    input  logic           rstn,
    program_loader_if.master bus
);

    localparam int          CNT_W   = ADDR_W + 1;
    localparam logic [31:0] MAX_LEN = 32'(IMEM_WORDS);

    state_e             state_q, state_d;
    logic [31:0]        len_q, len_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               core_rstn_q, core_rstn_d;
    logic               busy_q, busy_d;
    logic               load_err_q, load_err_d;

    logic               byte_en;
    logic [1:0]         byte_cnt;
    logic               word_valid;
    logic [31:0]        word;

    // Bytes outside S_LEN/S_LOAD never reach the assembler, so its count stays frozen.
    assign byte_en = bus.rx_valid && ((state_q == S_LEN) || (state_q == S_LOAD));

    byte_to_word u_byte_to_word (
        .clk        (clk),
        .rstn       (rstn),
        .byte_valid (byte_en),
        .byte_data  (bus.rx_data),
        .byte_cnt   (byte_cnt),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        core_rstn_d  = core_rstn_q;
        load_err_d   = load_err_q;

        unique case (state_q)
            S_LEN: begin
                if (word_valid) begin
                    len_d   = word;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                word_cnt_d = '0;
                if (len_q > MAX_LEN) begin
                    state_d    = S_ERR;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ERR_BYTE;
                    load_err_d = 1'b1;
                end else if (len_q == '0) begin
                    state_d    = S_ACK;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK_BYTE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (word_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                    imem_wdata_d = word;
                    word_cnt_d   = word_cnt_q + 1'b1;
                end
                // Leave only after the final write cycle so imem_we stays inside S_LOAD.
                if (imem_we_q && (word_cnt_q == len_q[CNT_W-1:0])) begin
                    state_d    = S_ACK;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK_BYTE;
                end
            end
            S_ACK: begin
                if (bus.tx_ready) begin
                    tx_valid_d  = 1'b0;
                    core_rstn_d = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
            end
            S_ERR: begin
                if (tx_valid_q && bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_LEN;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_CHECK) ||
                 ((state_d == S_LEN) && (byte_en || (byte_cnt != 2'd0)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_LEN;
            len_q        <= '0;
            word_cnt_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            core_rstn_q  <= 1'b0;
            busy_q       <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            core_rstn_q  <= core_rstn_d;
            busy_q       <= busy_d;
            load_err_q   <= load_err_d;
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.core_rstn  = core_rstn_q;
    assign bus.busy       = busy_q;
    assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: normal, zero, oversize, full, stall, reset cases.
module tb_program_loader;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];

    program_loader_if #(.ADDR_W(5)) bus ();

    program_loader #(
        .IMEM_WORDS (32),
        .ADDR_W     (5),
        .ACK_BYTE   (8'hAA),
        .ERR_BYTE   (8'hEE)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every imem write is logged so order, count and absence of stray writes can be checked.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr_log.push_back(32'(bus.imem_addr));
            wr_data_log.push_back(bus.imem_wdata);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        tick();
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int k = 0; k < 4; k++) applyStimulus(n[8*k +: 8]);
    endtask

    // Sends one word and checks the write appears exactly one cycle after its last byte.
    // With overlap set, the next word's first byte is driven during the write cycle itself.
    task automatic send_word(input logic [31:0] w, input logic [31:0] addr,
                             input bit first_sent, input bit overlap,
                             input logic [7:0] next_b0);
        for (int k = (first_sent ? 1 : 0); k < 3; k++) applyStimulus(w[8*k +: 8]);
        checkOutput("we_before", 32'(bus.imem_we), 32'd0);
        bus.rx_data  = w[31:24];
        bus.rx_valid = 1'b1;
        tick();
        checkOutput("we", 32'(bus.imem_we), 32'd1);
        checkOutput("addr", 32'(bus.imem_addr), addr);
        checkOutput("wdata", bus.imem_wdata, w);
        if (overlap) bus.rx_data = next_b0;
        bus.rx_valid = overlap;
        tick();
        bus.rx_valid = 1'b0;
        checkOutput("we_pulse", 32'(bus.imem_we), 32'd0);
        if (overlap) tick();
    endtask

    task automatic wait_tx(input logic [7:0] exp_byte);
        for (int i = 0; i < 100; i++) begin
            if (bus.tx_valid === 1'b1) break;
            tick();
        end
        checkOutput("tx_valid", 32'(bus.tx_valid), 32'd1);
        checkOutput("tx_data", 32'(bus.tx_data), 32'(exp_byte));
    endtask

    task automatic handshake();
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        repeat (3) tick();
        wr_addr_log.delete();
        wr_data_log.delete();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rstn         = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;

        // Reset values while reset is held.
        repeat (3) tick();
        checkOutput("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("rst_tx_data", 32'(bus.tx_data), 32'd0);
        checkOutput("rst_imem_we", 32'(bus.imem_we), 32'd0);
        checkOutput("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("rst_imem_wdata", bus.imem_wdata, 32'd0);
        checkOutput("rst_core_rstn", 32'(bus.core_rstn), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_load_err", 32'(bus.load_err), 32'd0);
        rstn = 1'b1;
        tick();

        // Length-2 load, second word's first byte overlapping the first write.
        applyStimulus(8'h02);
        checkOutput("busy_len", 32'(bus.busy), 32'd1);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        send_word(32'h00100093, 32'd0, 1'b0, 1'b1, 8'h13);
        checkOutput("busy_load", 32'(bus.busy), 32'd1);
        send_word(32'h00100113, 32'd1, 1'b1, 1'b0, 8'h00);
        wait_tx(8'hAA);
        checkOutput("l2_core_held", 32'(bus.core_rstn), 32'd0);
        handshake();
        checkOutput("l2_core_run", 32'(bus.core_rstn), 32'd1);
        checkOutput("l2_tx_done", 32'(bus.tx_valid), 32'd0);
        checkOutput("l2_busy_idle", 32'(bus.busy), 32'd0);
        checkOutput("l2_nwrites", 32'(wr_addr_log.size()), 32'd2);
        if (wr_addr_log.size() == 2) begin
            checkOutput("l2_log_a0", wr_addr_log[0], 32'd0);
            checkOutput("l2_log_d0", wr_data_log[0], 32'h00100093);
            checkOutput("l2_log_a1", wr_addr_log[1], 32'd1);
            checkOutput("l2_log_d1", wr_data_log[1], 32'h00100113);
        end

        // Zero length goes straight to the acknowledge.
        do_reset();
        send_len(32'd0);
        wait_tx(8'hAA);
        handshake();
        checkOutput("z_core_run", 32'(bus.core_rstn), 32'd1);
        checkOutput("z_nwrites", 32'(wr_addr_log.size()), 32'd0);

        // Oversize length 33: error byte, core stays in reset, later bytes ignored.
        do_reset();
        send_len(32'd33);
        wait_tx(8'hEE);
        checkOutput("o_load_err", 32'(bus.load_err), 32'd1);
        handshake();
        checkOutput("o_tx_done", 32'(bus.tx_valid), 32'd0);
        for (int k = 0; k < 8; k++) applyStimulus(8'h5A);
        checkOutput("o_nwrites", 32'(wr_addr_log.size()), 32'd0);
        checkOutput("o_core_held", 32'(bus.core_rstn), 32'd0);
        checkOutput("o_load_err_sticky", 32'(bus.load_err), 32'd1);
        checkOutput("o_tx_quiet", 32'(bus.tx_valid), 32'd0);

        // All-ones length must fail the full-width compare.
        do_reset();
        send_len(32'hFFFF_FFFF);
        wait_tx(8'hEE);
        checkOutput("ff_load_err", 32'(bus.load_err), 32'd1);

        // Full 32-word load followed by a 50-cycle transmit stall.
        do_reset();
        send_len(32'd32);
        for (int i = 0; i < 32; i++) send_word(32'(i * 4), 32'(i), 1'b0, 1'b0, 8'h00);
        wait_tx(8'hAA);
        checkOutput("f_nwrites", 32'(wr_addr_log.size()), 32'd32);
        if (wr_addr_log.size() == 32) begin
            checkOutput("f_last_addr", wr_addr_log[31], 32'd31);
            checkOutput("f_last_data", wr_data_log[31], 32'd124);
        end
        for (int i = 0; i < 50; i++) begin
            checkOutput("stall_valid", 32'(bus.tx_valid), 32'd1);
            checkOutput("stall_data", 32'(bus.tx_data), 32'hAA);
            checkOutput("stall_core", 32'(bus.core_rstn), 32'd0);
            tick();
        end
        handshake();
        checkOutput("f_core_run", 32'(bus.core_rstn), 32'd1);
        checkOutput("f_nwrites_final", 32'(wr_addr_log.size()), 32'd32);

        // Asynchronous reset in the middle of word 1, then a clean one-word reload.
        do_reset();
        send_len(32'd2);
        send_word(32'h11223344, 32'd0, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h55);
        applyStimulus(8'h66);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("ar_imem_wdata", bus.imem_wdata, 32'd0);
        checkOutput("ar_busy", 32'(bus.busy), 32'd0);
        checkOutput("ar_imem_we", 32'(bus.imem_we), 32'd0);
        checkOutput("ar_core_rstn", 32'(bus.core_rstn), 32'd0);
        checkOutput("ar_tx_valid", 32'(bus.tx_valid), 32'd0);
        do_reset();
        send_len(32'd1);
        send_word(32'hCAFEF00D, 32'd0, 1'b0, 1'b0, 8'h00);
        wait_tx(8'hAA);
        handshake();
        checkOutput("ar_core_run", 32'(bus.core_rstn), 32'd1);
        checkOutput("ar_nwrites", 32'(wr_addr_log.size()), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
